// File: rtl/dp_arbiter.sv
// dp_arbiter: shares one datapath among NUM_REQ sequencers, replaying the 2-cycle start protocol.
// Define DP_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest); default is round-robin.
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 16
`endif
`ifndef RESULT_WIDTH
`define RESULT_WIDTH 16
`endif

module dp_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int REQ_ID_WIDTH = 2
) (
  input  logic                                    clock,
  input  logic                                    resetn,
  input  logic [NUM_REQ-1:0]                      req_start,
  input  logic [NUM_REQ*`INSTRUCTION_WIDTH-1:0]   req_instruction,
  output logic [NUM_REQ-1:0]                      req_finished,
  output logic [`RESULT_WIDTH-1:0]                req_result,
  output logic                                    dp_start,
  output logic [`INSTRUCTION_WIDTH-1:0]           dp_instruction,
  input  logic                                    dp_finished,
  input  logic [`RESULT_WIDTH-1:0]                dp_result,
  output logic                                    busy,
  output logic [REQ_ID_WIDTH-1:0]                 grant_id
);
  localparam int IW = `INSTRUCTION_WIDTH;
  localparam int RW = `RESULT_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, WAIT} state_t;

  state_t                  state_q, state_d;
  logic [NUM_REQ-1:0]      pending_q, pending_d, cap, clr;
  logic [IW-1:0]           buf_q [NUM_REQ];
  logic [IW-1:0]           buf_d [NUM_REQ];
  logic [IW-1:0]           dp_instr_q, dp_instr_d;
  logic [RW-1:0]           result_q, result_d;
  logic                    dp_start_q, dp_start_d, busy_q, busy_d;
  logic [REQ_ID_WIDTH-1:0] grant_q, grant_d, sel, sel_lo;
`ifndef DP_ARB_FIXED_PRIO_EN
  logic [REQ_ID_WIDTH-1:0] rr_q, rr_d, sel_hi;
  logic                    hi_found;
`endif

  // A requester is idle exactly when it has nothing pending, so finished mirrors ~pending.
  assign cap = req_start & ~pending_q;

  always_comb begin
    sel_lo = '0;
`ifndef DP_ARB_FIXED_PRIO_EN
    sel_hi   = '0;
    hi_found = 1'b0;
`endif
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_lo = REQ_ID_WIDTH'(i);
`ifndef DP_ARB_FIXED_PRIO_EN
      if (pending_q[i] && i > int'(rr_q)) begin
        sel_hi   = REQ_ID_WIDTH'(i);
        hi_found = 1'b1;
      end
`endif
    end
`ifndef DP_ARB_FIXED_PRIO_EN
    sel = hi_found ? sel_hi : sel_lo;
`else
    sel = sel_lo;
`endif
  end

  always_comb begin
    state_d    = state_q;
    dp_start_d = dp_start_q;
    dp_instr_d = dp_instr_q;
    busy_d     = busy_q;
    grant_d    = grant_q;
    result_d   = result_q;
    clr        = '0;
`ifndef DP_ARB_FIXED_PRIO_EN
    rr_d       = rr_q;
`endif
    case (state_q)
      IDLE: if (|pending_q) begin
        grant_d    = sel;
        dp_instr_d = buf_q[sel];
        dp_start_d = 1'b1;
        busy_d     = 1'b1;
        state_d    = ISSUE;
      end
      ISSUE: state_d = HOLD;
      HOLD: begin
        dp_start_d = 1'b0;
        state_d    = WAIT;
      end
      WAIT: if (dp_finished) begin
        result_d     = dp_result;
        clr[grant_q] = 1'b1;
`ifndef DP_ARB_FIXED_PRIO_EN
        rr_d         = grant_q;
`endif
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pending_d = (pending_q | cap) & ~clr;
    for (int i = 0; i < NUM_REQ; i++) buf_d[i] = cap[i] ? req_instruction[i*IW +: IW] : buf_q[i];
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      dp_instr_q <= '0;
      result_q   <= '0;
      dp_start_q <= 1'b0;
      busy_q     <= 1'b0;
      grant_q    <= '0;
`ifndef DP_ARB_FIXED_PRIO_EN
      rr_q       <= REQ_ID_WIDTH'(NUM_REQ - 1);
`endif
      for (int i = 0; i < NUM_REQ; i++) buf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      dp_instr_q <= dp_instr_d;
      result_q   <= result_d;
      dp_start_q <= dp_start_d;
      busy_q     <= busy_d;
      grant_q    <= grant_d;
`ifndef DP_ARB_FIXED_PRIO_EN
      rr_q       <= rr_d;
`endif
      for (int i = 0; i < NUM_REQ; i++) buf_q[i] <= buf_d[i];
    end
  end

  assign req_finished   = ~pending_q;
  assign req_result     = result_q;
  assign dp_start       = dp_start_q;
  assign dp_instruction = dp_instr_q;
  assign busy           = busy_q;
  assign grant_id       = grant_q;
endmodule

// File: tb/tb_dp_arbiter.sv
// tb_dp_arbiter: randomized requesters and a variable-latency datapath, checked every cycle
// against a transaction-level model of the arbiter.
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 16
`endif
`ifndef RESULT_WIDTH
`define RESULT_WIDTH 16
`endif

module tb_dp_arbiter;
  localparam int N  = 4;
  localparam int IW = `INSTRUCTION_WIDTH;
  localparam int RW = `RESULT_WIDTH;

  logic              clock = 1'b0;
  logic              resetn = 1'b0;
  logic [N-1:0]      req_start = '0;
  logic [N*IW-1:0]   req_instruction = '0;
  logic [N-1:0]      req_finished;
  logic [RW-1:0]     req_result;
  logic              dp_start;
  logic [IW-1:0]     dp_instruction;
  logic              dp_finished = 1'b1;
  logic [RW-1:0]     dp_result = '0;
  logic              busy;
  logic [1:0]        grant_id;

  dp_arbiter #(.NUM_REQ(N), .REQ_ID_WIDTH(2)) dut (
    .clock(clock), .resetn(resetn), .req_start(req_start), .req_instruction(req_instruction),
    .req_finished(req_finished), .req_result(req_result), .dp_start(dp_start),
    .dp_instruction(dp_instruction), .dp_finished(dp_finished), .dp_result(dp_result),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: set of pending requests with their captured instruction, one transaction
  // in flight, aged in edges since its grant (dp_start expected for the first two).
  logic [N-1:0]  m_pend = '0;
  logic [IW-1:0] m_buf [N];
  logic [IW-1:0] m_instr = '0;
  logic [RW-1:0] m_res = '0;
  logic          m_busy = 1'b0;
  int            m_grant = 0;
  int            m_age = 0;
  int            m_rr = N - 1;
  logic [N-1:0]  nw;
  logic [N-1:0]  e_fin;
  int            cyc = 0;
  int            n_grants = 0;

  // Datapath model: latches instruction on a sampled start, finishes after a random delay.
  logic          s_dp_start = 1'b0;
  logic [IW-1:0] s_dp_instr = '0;
  logic          d_fin = 1'b1;
  int            d_cnt = 0;
  logic [IW-1:0] d_inst = '0;
  logic [RW-1:0] d_res = '0;

  function automatic int pick(input logic [N-1:0] p, input int r);
`ifdef DP_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (p[i]) return i;
`else
    for (int k = 1; k <= N; k++) if (p[(r + k) % N]) return (r + k) % N;
`endif
    return 0;
  endfunction

  initial foreach (m_buf[i]) m_buf[i] = '0;

  always @(posedge clock) begin
    if (!resetn) begin
      m_pend = '0;
      foreach (m_buf[i]) m_buf[i] = '0;
      m_instr = '0; m_res = '0; m_busy = 1'b0; m_grant = 0; m_age = 0; m_rr = N - 1;
      d_fin = 1'b1; d_cnt = 0;
    end else begin
      nw = req_start & ~m_pend;
      if (m_busy && m_age >= 3 && dp_finished) begin
        m_res = dp_result;
        m_pend[m_grant] = 1'b0;
        m_rr = m_grant;
        m_busy = 1'b0;
        m_age = 0;
      end else if (!m_busy && m_pend != '0) begin
        m_grant = pick(m_pend, m_rr);
        m_instr = m_buf[m_grant];
        m_busy = 1'b1;
        m_age = 1;
        n_grants++;
      end else if (m_busy && m_age < 3) m_age++;
      for (int i = 0; i < N; i++)
        if (nw[i]) begin
          m_pend[i] = 1'b1;
          m_buf[i] = req_instruction[i*IW +: IW];
        end
      if (d_cnt > 0) begin
        d_cnt--;
        if (d_cnt == 0) begin
          d_fin = 1'b1;
          d_res = RW'(d_inst * 7 + 1);
        end
      end else if (s_dp_start && d_fin) begin
        d_fin = 1'b0;
        d_cnt = $urandom_range(1, 6);
        d_inst = s_dp_instr;
      end
    end
    cyc++;
  end

  always @(negedge clock) begin
    s_dp_start = dp_start;
    s_dp_instr = dp_instruction;
    dp_finished = d_fin;
    dp_result = d_res;
    if (cyc > 0) begin
      e_fin = ~m_pend;
      check("req_finished", 64'(req_finished), 64'(e_fin));
      check("busy", 64'(busy), 64'(m_busy));
      check("grant_id", 64'(grant_id), 64'(m_grant));
      check("dp_start", 64'(dp_start), 64'(m_busy && m_age <= 2));
      check("dp_instruction", 64'(dp_instruction), 64'(m_instr));
      check("req_result", 64'(req_result), 64'(m_res));
    end
  end

  task automatic step(input logic [N-1:0] s, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #2 req_start = s;
    end
  endtask

  task automatic set_slot(input int i, input logic [IW-1:0] v);
    req_instruction[i*IW +: IW] = v;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #2 resetn = 1'b1;
    set_slot(1, IW'(16'h02A5));
    step(4'b0010, 2);
    step(4'b0000, 20);
    for (int i = 0; i < N; i++) set_slot(i, IW'($urandom));
    step(4'b1111, 1);
    step(4'b0000, 60);
    set_slot(0, IW'(16'h0111));
    step(4'b0001, 1);
    step(4'b0000, 5);
    set_slot(0, IW'(16'h0222));
    step(4'b0001, 2);
    step(4'b0000, 25);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock);
      #2;
      for (int i = 0; i < N; i++) set_slot(i, IW'($urandom));
      req_start = N'($urandom & $urandom);
      resetn = ($urandom_range(0, 249) != 0);
    end
    @(posedge clock);
    #2 resetn = 1'b1;
    req_start = '0;
    step(4'b0000, 60);
    @(negedge clock);
    check("drained_busy", 64'(busy), 64'(0));
    check("drained_finished", 64'(req_finished), 64'(4'b1111));
    check("grants_seen", 64'(n_grants > 100), 64'(1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
